// File: rtl/johnson_phase_decoder.sv
// Johnson phase decoder.
// Consumes the 4-bit Johnson counter state and turns each legal code into a
// registered one-hot 8-phase strobe plus a 3-bit phase index. It also checks
// that successive samples follow the Johnson sequence, maintains a lock FSM,
// counts completed cycles while locked and keeps a saturating error count.
module johnson_phase_decoder #(
  parameter int LOCK_CNT = 4,  // correct successor steps needed to lock (1..15)
  parameter int CW       = 8,  // completed-cycle counter width
  parameter int EW       = 8   // saturating error counter width
) (
  input  logic          clk,
  input  logic          rst,             // asynchronous, active-low
  input  logic          en,
  input  logic [3:0]    jc_q,
  input  logic          clr_err,
  output logic [7:0]    phase,
  output logic [2:0]    phase_idx,
  output logic          illegal,
  output logic          seq_err,
  output logic          illegal_sticky,
  output logic          seq_err_sticky,
  output logic          locked,
  output logic [CW-1:0] cycle_cnt,
  output logic [EW-1:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKING  = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_t;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  lock_state_t state;
  logic [3:0]  match;
  logic [2:0]  prev_idx;
  logic        prev_valid;

  logic        dec_legal;
  logic [2:0]  dec_idx;
  logic        succ_ok;
  logic        ill_hit;
  logic        seq_hit;
  logic        err_event;
  logic        wrap_hit;

  // Map the Johnson code to its phase index; everything else is illegal.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    dec_legal = 1'b1;
    dec_idx   = 3'd0;
    case (jc_q)
      4'b0000: dec_idx = 3'd0;
      4'b0001: dec_idx = 3'd1;
      4'b0011: dec_idx = 3'd2;
      4'b0111: dec_idx = 3'd3;
      4'b1111: dec_idx = 3'd4;
      4'b1110: dec_idx = 3'd5;
      4'b1100: dec_idx = 3'd6;
      4'b1000: dec_idx = 3'd7;
      default: dec_legal = 1'b0;
    endcase
  end

  // Classify the current sample against the previously seen index.
  always_comb begin
    // 3-bit addition wraps 7 -> 0, giving the mod-8 successor for free.
    succ_ok   = prev_valid && (dec_idx == 3'(prev_idx + 3'd1));
    ill_hit   = en && !dec_legal;
    seq_hit   = en && dec_legal && prev_valid && !succ_ok;
    err_event = ill_hit || seq_hit;
    wrap_hit  = en && dec_legal && succ_ok && (prev_idx == 3'd7) &&
                (state == ST_LOCKED);
  end

  // Phase outputs, error pulses and the previous-index tracker.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase      <= '0;
      phase_idx  <= '0;
      illegal    <= 1'b0;
      seq_err    <= 1'b0;
      prev_idx   <= '0;
      prev_valid <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      illegal <= ill_hit;
      seq_err <= seq_hit;
      if (en) begin
        if (dec_legal) begin
          phase      <= 8'b1 << dec_idx;
          phase_idx  <= dec_idx;
          prev_idx   <= dec_idx;
          prev_valid <= 1'b1;
        end else begin
          // An illegal code breaks the chain: the next legal code restarts it.
          phase      <= '0;
          prev_valid <= 1'b0;
        end
      end
    end
  end

  // Lock FSM with a registered locked flag; only advances on samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_UNLOCKED;
      match  <= '0;
      locked <= 1'b0;
    end else if (en) begin
      case (state)
        ST_UNLOCKED: begin
          if (dec_legal) begin
            state <= ST_LOCKING;
            match <= '0;
          end
        end
        ST_LOCKING: begin
          if (!dec_legal || !succ_ok) begin
            state <= ST_UNLOCKED;
            match <= '0;
          end else if (4'(match + 4'd1) == LOCK_TGT) begin
            state  <= ST_LOCKED;
            match  <= 4'(match + 4'd1);
            locked <= 1'b1;
          end else begin
            match <= 4'(match + 4'd1);
          end
        end
        ST_LOCKED: begin
          if (!dec_legal || !succ_ok) begin
            state  <= ST_UNLOCKED;
            match  <= '0;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= ST_UNLOCKED;
          match  <= '0;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // Completed-cycle counter: counts 7 -> 0 wraps seen while already locked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
    end else if (wrap_hit) begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  // Error bookkeeping; a coincident clear beats a new event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt        <= '0;
      illegal_sticky <= 1'b0;
      seq_err_sticky <= 1'b0;
    end else if (clr_err) begin
      err_cnt        <= '0;
      illegal_sticky <= 1'b0;
      seq_err_sticky <= 1'b0;
    end else begin
      if (ill_hit) illegal_sticky <= 1'b1;
      if (seq_hit) seq_err_sticky <= 1'b1;
      if (err_event && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Self-checking bench for johnson_phase_decoder.
// Two instances share stimulus: one with default widths and one with a 2-bit
// error counter to observe saturation. A rule-level reference model predicts
// every output after each clock edge.
module tb_johnson_phase_decoder;

  localparam int LOCK_CNT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] jc_q;
  logic       clr_err;

  logic [7:0] a_phase, b_phase;
  logic [2:0] a_idx, b_idx;
  logic       a_ill, b_ill, a_seq, b_seq, a_ills, b_ills, a_seqs, b_seqs;
  logic       a_lock, b_lock;
  logic [7:0] a_cyc, b_cyc;
  logic [7:0] a_err;
  logic [1:0] b_err;

  johnson_phase_decoder #(.LOCK_CNT(LOCK_CNT), .CW(8), .EW(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .jc_q(jc_q), .clr_err(clr_err),
    .phase(a_phase), .phase_idx(a_idx), .illegal(a_ill), .seq_err(a_seq),
    .illegal_sticky(a_ills), .seq_err_sticky(a_seqs), .locked(a_lock),
    .cycle_cnt(a_cyc), .err_cnt(a_err)
  );

  johnson_phase_decoder #(.LOCK_CNT(LOCK_CNT), .CW(8), .EW(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .jc_q(jc_q), .clr_err(clr_err),
    .phase(b_phase), .phase_idx(b_idx), .illegal(b_ill), .seq_err(b_seq),
    .illegal_sticky(b_ills), .seq_err_sticky(b_seqs), .locked(b_lock),
    .cycle_cnt(b_cyc), .err_cnt(b_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state, expressed in terms of the behavioural rules.
  int m_phase, m_idx, m_ill, m_seq, m_ills, m_seqs;
  int m_prev, m_pv;
  int m_streak;   // -1: no reference; else correct successors since reference
  int m_cyc, m_err_a, m_err_b;

  int stim_k;     // index of the last legal code driven

  function automatic logic [3:0] code_of(input int k);
    logic [3:0] t [8];
    t = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    return t[k % 8];
  endfunction

  function automatic int idx_of(input logic [3:0] q);
    for (int i = 0; i < 8; i++) if (code_of(i) == q) return i;
    return -1;
  endfunction

  function automatic logic [3:0] bad_code(input int k);
    logic [3:0] t [8];
    t = '{4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1011, 4'b1101};
    return t[k % 8];
  endfunction

  task automatic model_reset();
    m_phase = 0; m_idx = 0; m_ill = 0; m_seq = 0; m_ills = 0; m_seqs = 0;
    m_prev = 0; m_pv = 0; m_streak = -1; m_cyc = 0; m_err_a = 0; m_err_b = 0;
  endtask

  task automatic model_step(input logic e, input logic [3:0] q, input logic c);
    int k;
    int was_locked;
    m_ill = 0;
    m_seq = 0;
    if (e) begin
      k = idx_of(q);
      was_locked = (m_streak >= LOCK_CNT);
      if (k >= 0) begin
        m_seq = (m_pv != 0) && (k != (m_prev + 1) % 8);
        if (was_locked && m_pv != 0 && m_prev == 7 && k == 0) m_cyc = (m_cyc + 1) % 256;
        if (m_seq) m_streak = (m_streak >= 0) ? -1 : 0;
        else if (m_streak >= 0) m_streak = (m_streak < 1000) ? m_streak + 1 : m_streak;
        else m_streak = 0;
        m_phase = 1 << k;
        m_idx = k;
        m_prev = k;
        m_pv = 1;
      end else begin
        m_ill = 1;
        m_phase = 0;
        m_pv = 0;
        m_streak = -1;
      end
    end
    if (c) begin
      m_ills = 0; m_seqs = 0; m_err_a = 0; m_err_b = 0;
    end else begin
      if (m_ill) m_ills = 1;
      if (m_seq) m_seqs = 1;
      if (m_ill || m_seq) begin
        if (m_err_a < 255) m_err_a++;
        if (m_err_b < 3) m_err_b++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int lk;
    lk = (m_streak >= LOCK_CNT) ? 1 : 0;
    check("a.phase", 32'(a_phase), 32'(m_phase));
    check("a.phase_idx", 32'(a_idx), 32'(m_idx));
    check("a.illegal", 32'(a_ill), 32'(m_ill));
    check("a.seq_err", 32'(a_seq), 32'(m_seq));
    check("a.illegal_sticky", 32'(a_ills), 32'(m_ills));
    check("a.seq_err_sticky", 32'(a_seqs), 32'(m_seqs));
    check("a.locked", 32'(a_lock), 32'(lk));
    check("a.cycle_cnt", 32'(a_cyc), 32'(m_cyc));
    check("a.err_cnt", 32'(a_err), 32'(m_err_a));
    check("b.phase", 32'(b_phase), 32'(m_phase));
    check("b.locked", 32'(b_lock), 32'(lk));
    check("b.illegal", 32'(b_ill), 32'(m_ill));
    check("b.illegal_sticky", 32'(b_ills), 32'(m_ills));
    check("b.err_cnt", 32'(b_err), 32'(m_err_b));
  endtask

  task automatic step(input logic e, input logic [3:0] q, input logic c);
    en = e;
    jc_q = q;
    clr_err = c;
    if (e && idx_of(q) >= 0) stim_k = idx_of(q);
    @(posedge clk);
    model_step(e, q, c);
    #1;
    check_all();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    stim_k = 7;
  endtask

  initial begin
    int r;
    rst = 1'b0;
    en = 1'b0;
    jc_q = 4'b0000;
    clr_err = 1'b0;
    stim_k = 7;
    model_reset();
    #2;
    apply_reset();

    // Counter running from 0000 for 16 steps: walk, lock, cycle count.
    for (int i = 0; i < 16; i++) step(1'b1, code_of(i), 1'b0);

    // Illegal injection while locked, then recovery from 0011 and relock.
    step(1'b1, 4'b0101, 1'b0);
    for (int i = 2; i <= 6; i++) step(1'b1, code_of(i), 1'b0);

    // Skipped state 0011 -> 1111, then a repeated 1111.
    for (int i = 7; i <= 10; i++) step(1'b1, code_of(i), 1'b0);
    step(1'b1, 4'b1111, 1'b0);
    step(1'b1, 4'b1111, 1'b0);

    // en low for 10 cycles while jc_q wanders: everything frozen.
    for (int i = 0; i < 10; i++) step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
    step(1'b1, 4'b1110, 1'b0);

    // Clear, then 5 illegals with a clear coinciding with the 5th.
    step(1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, bad_code(i), (i == 4) ? 1'b1 : 1'b0);

    // Randomized mix of good steps, glitches, idle cycles and clears.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      step(1'b1, code_of(stim_k + 1), ($urandom_range(0, 19) == 0));
      else if (r < 78) step(1'b1, code_of($urandom_range(0, 7)), 1'b0);
      else if (r < 85) step(1'b1, bad_code($urandom_range(0, 7)), ($urandom_range(0, 19) == 0));
      else if (r < 95) step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
      else             step(1'b0, 4'($urandom_range(0, 15)), 1'b1);
    end

    // Fresh start, run to three locked cycles, then async reset mid-cycle.
    apply_reset();
    for (int i = 0; i < 25; i++) step(1'b1, code_of(i), 1'b0);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    #2;
    rst = 1'b1;
    step(1'b1, 4'b1100, 1'b0);
    step(1'b1, 4'b1000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
